// File: rtl/gpio_bank_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_bank_controller_if : REQ/ACK command and response channels between the |
// | IO manager (master) and a GPIO bank (slave).            Revision: 1.0      |
// +----------------------------------------------------------------------------+
interface gpio_bank_controller_if #(
  parameter int GPIOWIDTH = 16
) ();
  logic                 IOOut_REQ;
  logic                 IOOut_ACK;
  logic                 IOOut_ResponseRequested;
  logic [3:0]           IOOut_DestReg;
  logic [3:0]           IOOut_Cmd;
  logic [GPIOWIDTH-1:0] IOOut_Data;
  logic                 IOIn_REQ;
  logic                 IOIn_ACK;
  logic                 IOIn_RegResponseFlag;
  logic                 IOIn_MemResponseFlag;
  logic [3:0]           IOIn_DestReg;
  logic [GPIOWIDTH-1:0] IOIn_Data;

  modport master (
    output IOOut_REQ, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Cmd, IOOut_Data,
    input  IOOut_ACK,
    input  IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag, IOIn_DestReg, IOIn_Data,
    output IOIn_ACK
  );

  modport slave (
    input  IOOut_REQ, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Cmd, IOOut_Data,
    output IOOut_ACK,
    output IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag, IOIn_DestReg, IOIn_Data,
    input  IOIn_ACK
  );
endinterface
`default_nettype wire

// File: rtl/gpio_bank_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_bank_controller : parametrised GPIO bank with atomic set/clear/toggle, |
// | input synchroniser and optional edge capture (GPIO_EDGE_CAPTURE_EN).        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gpio_bank_controller #(
  parameter int GPIOWIDTH  = 16,
  parameter int SYNCSTAGES = 2
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst_n,
  gpio_bank_controller_if.slave bus,
  input  logic [GPIOWIDTH-1:0]  GPIO_DIn,
  output logic [GPIOWIDTH-1:0]  GPIO_DOut,
  output logic [GPIOWIDTH-1:0]  GPIO_DOutEn,
  output logic                  EdgeIRQ
);
  localparam logic [3:0] c_READ_PIN      = 4'd0;
  localparam logic [3:0] c_WRITE_OUT     = 4'd1;
  localparam logic [3:0] c_WRITE_OE      = 4'd2;
  localparam logic [3:0] c_SET           = 4'd3;
  localparam logic [3:0] c_CLEAR         = 4'd4;
  localparam logic [3:0] c_TOGGLE        = 4'd5;
  localparam logic [3:0] c_WRITE_RISE_EN = 4'd6;
  localparam logic [3:0] c_WRITE_FALL_EN = 4'd7;
  localparam logic [3:0] c_READ_CLR_EDGE = 4'd8;
  localparam logic [3:0] c_READ_OUT      = 4'd9;
  localparam logic [3:0] c_READ_OE       = 4'd10;

  typedef enum logic [0:0] {IDLE = 1'b0, RESPOND = 1'b1} state_t;

  state_t                                r_state;
  logic                                  r_ack;
  logic                                  r_req;
  logic                                  r_regFlag;
  logic [3:0]                            r_dest;
  logic [GPIOWIDTH-1:0]                  r_data;
  logic [GPIOWIDTH-1:0]                  r_dout;
  logic [GPIOWIDTH-1:0]                  r_oe;
  logic [SYNCSTAGES-1:0][GPIOWIDTH-1:0]  r_sync;

  logic                 w_xfer;
  logic [GPIOWIDTH-1:0] w_syncIn;
  logic [GPIOWIDTH-1:0] w_doutNext;
  logic [GPIOWIDTH-1:0] w_oeNext;
  logic [GPIOWIDTH-1:0] w_rdata;

  assign w_xfer   = bus.IOOut_REQ & r_ack & clk_en;
  assign w_syncIn = r_sync[SYNCSTAGES-1];

`ifdef GPIO_EDGE_CAPTURE_EN
  logic [GPIOWIDTH-1:0] r_hist;
  logic [GPIOWIDTH-1:0] r_riseEn;
  logic [GPIOWIDTH-1:0] r_fallEn;
  logic [GPIOWIDTH-1:0] r_flags;
  logic                 r_irq;
  logic [GPIOWIDTH-1:0] w_clr;
  logic [GPIOWIDTH-1:0] w_flagsNext;

  // A newly detected edge is OR-ed in after the clear, so it survives a same-cycle clear.
  assign w_clr       = (w_xfer && bus.IOOut_Cmd == c_READ_CLR_EDGE) ? bus.IOOut_Data : '0;
  assign w_flagsNext = (r_flags & ~w_clr)
                     | (w_syncIn & ~r_hist & r_riseEn)
                     | (~w_syncIn & r_hist & r_fallEn);

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_hist   <= '0;
      r_riseEn <= '0;
      r_fallEn <= '0;
      r_flags  <= '0;
      r_irq    <= 1'b0;
    end else if (clk_en) begin
      r_hist  <= w_syncIn;
      r_flags <= w_flagsNext;
      r_irq   <= |w_flagsNext;
      if (w_xfer && bus.IOOut_Cmd == c_WRITE_RISE_EN) r_riseEn <= bus.IOOut_Data;
      if (w_xfer && bus.IOOut_Cmd == c_WRITE_FALL_EN) r_fallEn <= bus.IOOut_Data;
    end
  end

  assign EdgeIRQ = r_irq;
`else
  assign EdgeIRQ = 1'b0;
`endif

  always_comb begin
    w_doutNext = r_dout;
    w_oeNext   = r_oe;
    w_rdata    = '1;
    case (bus.IOOut_Cmd)
      c_READ_PIN:  w_rdata = w_syncIn;
      c_WRITE_OUT: begin w_doutNext = bus.IOOut_Data;            w_rdata = bus.IOOut_Data;            end
      c_WRITE_OE:  begin w_oeNext   = bus.IOOut_Data;            w_rdata = bus.IOOut_Data;            end
      c_SET:       begin w_doutNext = r_dout | bus.IOOut_Data;   w_rdata = r_dout | bus.IOOut_Data;   end
      c_CLEAR:     begin w_doutNext = r_dout & ~bus.IOOut_Data;  w_rdata = r_dout & ~bus.IOOut_Data;  end
      c_TOGGLE:    begin w_doutNext = r_dout ^ bus.IOOut_Data;   w_rdata = r_dout ^ bus.IOOut_Data;   end
`ifdef GPIO_EDGE_CAPTURE_EN
      c_WRITE_RISE_EN: w_rdata = bus.IOOut_Data;
      c_WRITE_FALL_EN: w_rdata = bus.IOOut_Data;
      c_READ_CLR_EDGE: w_rdata = r_flags;
`endif
      c_READ_OUT:  w_rdata = r_dout;
      c_READ_OE:   w_rdata = r_oe;
      default:     w_rdata = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_req     <= 1'b0;
      r_regFlag <= 1'b0;
      r_dest    <= '0;
      r_data    <= '0;
      r_dout    <= '0;
      r_oe      <= '0;
      r_sync    <= '0;
    end else if (clk_en) begin
      r_sync <= {r_sync[SYNCSTAGES-2:0], GPIO_DIn};
      if (w_xfer) begin
        r_dout <= w_doutNext;
        r_oe   <= w_oeNext;
      end
      case (r_state)
        IDLE: begin
          r_ack <= 1'b1;
          if (w_xfer && bus.IOOut_ResponseRequested) begin
            r_state   <= RESPOND;
            r_ack     <= 1'b0;
            r_req     <= 1'b1;
            r_regFlag <= 1'b1;
            r_data    <= w_rdata;
            r_dest    <= bus.IOOut_DestReg;
          end
        end
        RESPOND: begin
          if (bus.IOIn_ACK) begin
            r_state   <= IDLE;
            r_ack     <= 1'b1;
            r_req     <= 1'b0;
            r_regFlag <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.IOOut_ACK            = r_ack;
  assign bus.IOIn_REQ             = r_req;
  assign bus.IOIn_RegResponseFlag = r_regFlag;
  assign bus.IOIn_MemResponseFlag = 1'b0;
  assign bus.IOIn_DestReg         = r_dest;
  assign bus.IOIn_Data            = r_data;
  assign GPIO_DOut                = r_dout;
  assign GPIO_DOutEn              = r_oe;
endmodule
`default_nettype wire
